// File: rtl/reg_file_onehot.sv
// reg_file_onehot: 16-entry register file with one-hot write strobe.
// R0..R14 are stored; R15 reads return r15_in (PC+8). Three combinational
// read ports, one clocked write port, sticky strobe error flag and a
// wrapping count of accepted writes.
module reg_file_onehot #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          BYPASS = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [15:0]      wr_sel,
    input  logic [WIDTH-1:0] wd,
    input  logic [3:0]       ra1,
    input  logic [3:0]       ra2,
    input  logic [3:0]       ra3,
    input  logic [WIDTH-1:0] r15_in,
    input  logic             clr_err,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic [WIDTH-1:0] rd3,
    output logic             err,
    output logic [7:0]       wr_count
);

    logic [WIDTH-1:0] regs [15];
    logic             strobe_onehot;
    logic             wr_accept;
    logic             wr_illegal;
    logic [14:0]      wr_hit;

    // Classify the strobe: exactly one bit set, and whether it targets storage
    always_comb begin
        strobe_onehot = (wr_sel != '0) && ((wr_sel & (wr_sel - 16'd1)) == '0);
        // rst_n gating keeps the bypass path from forwarding a write that reset will discard
        wr_accept     = rst_n && we && strobe_onehot && !wr_sel[15];
        wr_illegal    = we && !strobe_onehot;
        wr_hit        = wr_accept ? wr_sel[14:0] : '0;
    end

    // Register storage: one strobe bit per register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 15; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 15; i++) begin
                if (wr_hit[i]) begin
                    regs[i] <= wd;
                end
            end
        end
    end

    // Sticky error flag (set beats clear) and wrapping write counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err      <= 1'b0;
            wr_count <= '0;
        end else begin
            if (wr_illegal) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end
            if (wr_accept) begin
                wr_count <= wr_count + 8'd1;
            end
        end
    end

    // One read port: R15 maps to r15_in and is never forwarded
    function automatic logic [WIDTH-1:0] read_port(input logic [3:0] a);
        logic [WIDTH-1:0] v;
        v = r15_in;
        for (int unsigned i = 0; i < 15; i++) begin
            if (a == 4'(i)) begin
                v = (BYPASS && wr_hit[i]) ? wd : regs[i];
            end
        end
        return v;
    endfunction

    // Three independent combinational read ports
    always_comb begin
        rd1 = read_port(ra1);
        rd2 = read_port(ra2);
        rd3 = read_port(ra3);
    end

endmodule
